alu_serial_seq: RTL and testbench

Bit-serial N-bit ALU sequencer. It accepts full-width operands and an opcode over a valid/ready handshake. It evaluates the operation one bit per clock, LSB first, using the team's standard 1-bit ALU slice function with a registered carry chain. It returns the full-width result and flags over a second valid/ready handshake. It is the multi-cycle, area-minimal ALU front end: it drives the per-bit `op`/`bnegate`/`cin` controls and consumes each bit's `result`/`cout`.

---
 rtl/alu_serial_seq.sv | 117 +++++++++++
 tb/tb_alu_serial_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer, one bit per clock LSB first, with valid/ready on both sides
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             bnegate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, full;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bneg_q, bneg_d, c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             ai, bi, sum, co, rbit, arith, last;
  // State and datapath registers; reset discards any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      op_q     <= '0;
      bneg_q   <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      op_q     <= op_d;
      bneg_q   <= bneg_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end
  // 1-bit ALU slice, next-state sequencing and state-decoded handshake outputs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    op_d     = op_q;
    bneg_d   = bneg_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    ai       = a_q[0];
    bi       = b_q[0] ^ bneg_q;
    sum      = ai ^ bi ^ c_q;
    co       = (ai & bi) | (c_q & (ai ^ bi));
    arith    = op_q[2:1] == 2'b10;
    rbit     = op_q == 3'b000 ? ai & bi :
               op_q == 3'b010 ? ai | bi :
               op_q == 3'b011 ? ai ^ bi :
               arith          ? sum     : ai;
    full     = {rbit, sh_q};
    last     = cnt_q == CW'(WIDTH - 1);
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      op_d    = op;
      bneg_d  = bnegate;
      c_d     = bnegate;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      sh_d  = full[WIDTH-1:1];
      c_d   = co;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d  = DONE;
        result_d = full;
        cout_d   = arith & co;
        ovf_d    = arith & (c_q ^ co);
        zero_d   = ~|full;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed checks of the serial ALU sequencer with hand-computed results
module tb_alu_serial_seq;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, bnegate = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, cout, overflow, zero, busy;
  int          checks = 0, errors = 0, lat;
  logic [31:0] held;

  alu_serial_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .bnegate(bnegate),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top, input logic tbn);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a = ta; b = tb; op = top; bnegate = tbn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom); bnegate = 1'b1;
  endtask

  task automatic wait_done();
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                     input logic tbn, input logic [31:0] er, input logic ec, input logic eo, input logic ez);
    start(ta, tb, top, tbn);
    wait_done();
    check({tag, "_latency"}, lat, 32);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
    check({tag, "_overflow"}, {31'b0, overflow}, {31'b0, eo});
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    take();
  endtask

  initial begin
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'b0, cout, overflow, zero}, 32'd0);
    #13 reset = 1'b0;
    @(posedge clk); #1;
    txn("add_5_7",    32'd5,        32'd7,        3'b100, 1'b0, 32'd12,       1'b0, 1'b0, 1'b0);
    txn("sub_5_7",    32'd5,        32'd7,        3'b100, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    txn("sub_7_7",    32'd7,        32'd7,        3'b100, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1);
    txn("add_ovf",    32'h7FFFFFFF, 32'd1,        3'b100, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    txn("add_wrap",   32'hFFFFFFFF, 32'd1,        3'b100, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1);
    txn("add_op101",  32'd1,        32'd2,        3'b101, 1'b0, 32'd3,        1'b0, 1'b0, 1'b0);
    txn("and",        32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    txn("or",         32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    txn("xor",        32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    txn("pass001",    32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
    txn("pass110",    32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
    txn("pass111",    32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
    txn("and_bneg",   32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b1, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
    txn("xor_bneg",   32'hFFFFFFFF, 32'h00000000, 3'b011, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    start(32'd100, 32'd23, 3'b100, 1'b0);
    wait_done();
    check("bp_latency", lat, 32);
    held = result;
    check("bp_result", held, 32'd123);
    in_valid = 1'b1; a = 32'd1; b = 32'd1; op = 3'b100; bnegate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, 32'd123);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    take();
    check("bp_after_take_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_after_take_result", result, 32'd123);
    txn("bp_next",    32'd40,       32'd2,        3'b100, 1'b0, 32'd42,       1'b0, 1'b0, 1'b0);
    txn("pre_abort",  32'd0,        32'd0,        3'b100, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1);
    start(32'hFFFFFFFF, 32'h0000FFFF, 3'b100, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", {29'b0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_out_valid", {31'b0, out_valid}, 32'd0);
    txn("after_abort", 32'd3,       32'd4,        3'b100, 1'b0, 32'd7,        1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
